// File: rtl/led_status_arbiter_if.sv
// Status LED arbiter bus: requester controls in, LED drive and debug status out.
interface led_status_arbiter_if #(
  parameter int unsigned CODE_W = 4
);
  logic              force_on;
  logic              hb_en;
  logic              err_req;
  logic [CODE_W-1:0] err_code;
  logic              err_clr;
  logic              led;
  logic              err_active;
  logic              tick;

  // Requester side: drives the controls and observes the LED.
  modport master (
    output force_on, hb_en, err_req, err_code, err_clr,
    input  led, err_active, tick
  );

  // Arbiter side: owns the LED.
  modport slave (
    input  force_on, hb_en, err_req, err_code, err_clr,
    output led, err_active, tick
  );
endinterface

// File: rtl/led_status_arbiter.sv
// Sole owner of the board status LED. Fixed priority:
// force-on > error blink code > heartbeat. Error codes play as N short
// pulses followed by a gap, repeating until cleared.
module led_status_arbiter #(
  parameter int unsigned TICK_DIV  = 50_000_000 / 8,
  parameter int unsigned GAP_TICKS = 6,
  parameter int unsigned HB_TICKS  = 4,
  parameter int unsigned CODE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  led_status_arbiter_if.slave bus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GW = $clog2(GAP_TICKS + 1);
  localparam int unsigned HW = $clog2(HB_TICKS + 1);

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0]     GAP_LOAD  = GW'(GAP_TICKS);
  localparam logic [GW-1:0]     GAP_ONE   = GW'(1);
  localparam logic [HW-1:0]     HB_LAST   = HW'(HB_TICKS - 1);
  localparam logic [CODE_W-1:0] PULSE_ONE = CODE_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_ON  = 2'd1,
    PULSE_OFF = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [HW-1:0]     hb_cnt;
  logic              hb_phase;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] pulse_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              err_active_q;
  logic              led_q;
  logic              led_next;
  logic              req_ok;

  // A request is accepted only with a non-zero code and no simultaneous clear.
  assign req_ok = bus.err_req & (|bus.err_code) & ~bus.err_clr;
  assign tick   = (tick_cnt == TICK_LAST);

  // Blink tick divider; realigned on an accepted request so the first pulse is a full tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (req_ok || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Free-running heartbeat phase, toggles every HB_TICKS ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt   <= '0;
      hb_phase <= 1'b0;
    end else if (tick) begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt   <= '0;
        hb_phase <= ~hb_phase;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // Error code playback FSM; clear beats request, and both strobes beat the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      code_q       <= '0;
      pulse_cnt    <= '0;
      gap_cnt      <= '0;
      err_active_q <= 1'b0;
    end else if (bus.err_clr) begin
      state        <= IDLE;
      pulse_cnt    <= '0;
      gap_cnt      <= '0;
      err_active_q <= 1'b0;
    end else if (req_ok) begin
      state        <= PULSE_ON;
      code_q       <= bus.err_code;
      pulse_cnt    <= bus.err_code;
      gap_cnt      <= '0;
      err_active_q <= 1'b1;
    end else if (tick) begin
      case (state)
        PULSE_ON: begin
          state <= PULSE_OFF;
        end
        PULSE_OFF: begin
          if (pulse_cnt == PULSE_ONE) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state     <= PULSE_ON;
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state     <= PULSE_ON;
            pulse_cnt <= code_q;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Owner select: force-on, then active error code, then heartbeat.
  always_comb begin
    led_next = 1'b0;
    if (bus.force_on) begin
      led_next = 1'b1;
    end else if (err_active_q) begin
      led_next = (state == PULSE_ON);
    end else if (bus.hb_en) begin
      led_next = hb_phase;
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_next;
    end
  end

  assign bus.led        = led_q;
  assign bus.err_active = err_active_q;
  assign bus.tick       = tick;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter with TICK_DIV=4, GAP_TICKS=3, HB_TICKS=2.
module tb_led_status_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  led_status_arbiter_if #(.CODE_W(4)) bus ();

  led_status_arbiter #(
    .TICK_DIV (4),
    .GAP_TICKS(3),
    .HB_TICKS (2),
    .CODE_W   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; sample point is 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected LED for code playback, k = edges since the accepted strobe edge.
  // Each pulse: 4 clk on, 4 clk off; gap 12 clk; LED lags FSM by one clock.
  function automatic int pat(input int k, input int code);
    int per;
    int m;
    if (k < 1) return 0;
    per = code * 8 + 12;
    m   = (k - 1) % per;
    return ((m < code * 8) && ((m % 8) < 4)) ? 1 : 0;
  endfunction

  // Heartbeat phase after edge m (counted from reset release), before the tick realign.
  function automatic int hbp_a(input int m);
    return (m / 8) % 2;
  endfunction

  // Heartbeat phase after edge m once the strobe at edge 53 realigned ticks.
  function automatic int hbp_b(input int m);
    if (m < 57) return 0;
    return (((m - 57) / 8) % 2 == 0) ? 1 : 0;
  endfunction

  initial begin
    int highs;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.force_on = 1'b0;
    bus.hb_en    = 1'b0;
    bus.err_req  = 1'b0;
    bus.err_code = '0;
    bus.err_clr  = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst led", bus.led, 0);
    check("rst err_active", bus.err_active, 0);
    check("rst tick", bus.tick, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();

    // Code 3 playback
    bus.err_req = 1'b1;
    bus.err_code = 4'd3;
    cyc();
    bus.err_req = 1'b0;
    bus.err_code = '0;
    for (int k = 0; k <= 45; k++) begin
      if (k > 0) cyc();
      check($sformatf("c3 led k=%0d", k), bus.led, pat(k, 3));
      check($sformatf("c3 act k=%0d", k), bus.err_active, 1);
      if (k < 12) check($sformatf("c3 tick k=%0d", k), bus.tick, (k % 4 == 3) ? 1 : 0);
    end

    // Asynchronous reset mid-playback (LED currently high)
    #2 rst = 1'b1;
    #1;
    check("async rst led", bus.led, 0);
    check("async rst err_active", bus.err_active, 0);
    check("async rst tick", bus.tick, 0);
    cyc();
    cyc();
    rst = 1'b0;

    // No pulses after release; n counts edges since release
    highs = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (bus.led || bus.err_active) highs++;
      if (n <= 8) check($sformatf("idle tick n=%0d", n), bus.tick, (n % 4 == 3) ? 1 : 0);
    end
    check("post-rst no activity", highs, 0);

    // Heartbeat only
    bus.hb_en = 1'b1;
    for (int n = 21; n <= 52; n++) begin
      cyc();
      check($sformatf("hb led n=%0d", n), bus.led, hbp_a(n - 1));
    end

    // Code 2 overrides heartbeat, then clear restores it
    bus.err_req = 1'b1;
    bus.err_code = 4'd2;
    for (int n = 53; n <= 70; n++) begin
      cyc();
      bus.err_req = 1'b0;
      bus.err_code = '0;
      check($sformatf("hb/c2 led n=%0d", n), bus.led, pat(n - 53, 2));
      check($sformatf("hb/c2 act n=%0d", n), bus.err_active, 1);
    end
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    check("clr act n=71", bus.err_active, 0);
    check("clr led n=71", bus.led, 0);
    for (int n = 72; n <= 90; n++) begin
      cyc();
      check($sformatf("hb restore led n=%0d", n), bus.led, hbp_b(n - 1));
      check($sformatf("hb restore act n=%0d", n), bus.err_active, 0);
    end

    // Force-on during code 2 playback
    bus.hb_en = 1'b0;
    cyc();
    cyc();
    bus.err_req = 1'b1;
    bus.err_code = 4'd2;
    cyc();
    bus.err_req = 1'b0;
    bus.err_code = '0;
    check("force led k=0", bus.led, 0);
    for (int k = 1; k <= 40; k++) begin
      bus.force_on = (k >= 3 && k <= 22);
      cyc();
      check($sformatf("force led k=%0d", k), bus.led, (k >= 3 && k <= 22) ? 1 : pat(k, 2));
      check($sformatf("force act k=%0d", k), bus.err_active, 1);
    end
    bus.force_on = 1'b0;

    // err_req(code 5) with err_clr: clear wins, tick counter not realigned
    bus.err_req = 1'b1;
    bus.err_code = 4'd5;
    bus.err_clr = 1'b1;
    highs = 0;
    for (int k = 41; k <= 60; k++) begin
      cyc();
      bus.err_req = 1'b0;
      bus.err_code = '0;
      bus.err_clr = 1'b0;
      if (bus.led) highs++;
      check($sformatf("req+clr act k=%0d", k), bus.err_active, 0);
      if (k <= 48) check($sformatf("req+clr tick k=%0d", k), bus.tick, (k % 4 == 3) ? 1 : 0);
    end
    check("req+clr no pulses", highs, 0);

    // err_req with code 0 in IDLE is ignored
    bus.err_req = 1'b1;
    bus.err_code = 4'd0;
    for (int k = 61; k <= 70; k++) begin
      cyc();
      bus.err_req = 1'b0;
      check($sformatf("code0 act k=%0d", k), bus.err_active, 0);
      check($sformatf("code0 led k=%0d", k), bus.led, 0);
      check($sformatf("code0 tick k=%0d", k), bus.tick, (k % 4 == 3) ? 1 : 0);
    end

    // Code 4, restarted as code 1 during GAP on a tick cycle
    bus.err_req = 1'b1;
    bus.err_code = 4'd4;
    cyc();
    bus.err_req = 1'b0;
    bus.err_code = '0;
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) cyc();
      check($sformatf("c4 led k=%0d", k), bus.led, pat(k, 4));
      check($sformatf("c4 act k=%0d", k), bus.err_active, 1);
      check($sformatf("c4 tick k=%0d", k), bus.tick, (k % 4 == 3) ? 1 : 0);
    end
    bus.err_req = 1'b1;
    bus.err_code = 4'd1;
    for (int j = 0; j <= 45; j++) begin
      cyc();
      bus.err_req = 1'b0;
      bus.err_code = '0;
      check($sformatf("c1 led j=%0d", j), bus.led, pat(j, 1));
      check($sformatf("c1 act j=%0d", j), bus.err_active, 1);
      if (j < 12) check($sformatf("c1 tick j=%0d", j), bus.tick, (j % 4 == 3) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
